// File: rtl/vga2tmds_encoder.sv
// -----------------------------------------------------------------------------
// vga2tmds_encoder
//   DVI 1.0 TMDS 8b/10b encoder. Takes an RGB888 pixel stream with
//   hsync/vsync/blank and produces one 10-bit TMDS symbol per channel per
//   pixel, plus a constant 10-bit pixel-clock pattern. Each channel keeps its
//   own running DC disparity. Serialization happens downstream.
//
//   Optional feature macro: TMDS_CLK_ENA_EN
//     defined   : every register advances only when clk_pixel_ena=1
//     undefined : clk_pixel_ena is ignored, pipeline advances every edge
//
//   Ports
//     clk_pixel      in   1   pixel clock, rising edge
//     resetn         in   1   asynchronous active-low reset
//     clk_pixel_ena  in   1   pixel qualifier (TMDS_CLK_ENA_EN builds only)
//     i_r/i_g/i_b    in   8   pixel colour, used when i_blank=0
//     i_hsync        in   1   horizontal sync, sent on blue during blank
//     i_vsync        in   1   vertical sync, sent on blue during blank
//     i_blank        in   1   1 = control period, 0 = data enable
//     o_red          out  10  lane 2 symbol
//     o_green        out  10  lane 1 symbol
//     o_blue         out  10  lane 0 symbol
//     o_clk          out  10  c_clk_pattern
//
//   Latency: 2 cycles (c_out_reg=0) or 3 cycles (c_out_reg=1), counted in
//   advancing cycles.
// -----------------------------------------------------------------------------

// One TMDS lane: transition minimisation stage, DC balance stage, optional
// output register.
module vga2tmds_channel #(
  parameter int c_out_reg = 1
) (
  input  logic       clk_pixel,
  input  logic       resetn,
  input  logic       adv,
  input  logic [7:0] d,
  input  logic       de,
  input  logic [1:0] ctrl,
  output logic [9:0] sym
);

  // Count of set bits in a byte (0..8).
  function automatic logic [3:0] ones8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int k = 0; k < 8; k++) begin
      n = n + {3'b000, v[k]};
    end
    return n;
  endfunction

  // Transition-minimised 9-bit word; bit 8 set means the XOR chain was used.
  function automatic logic [8:0] tm_qm(input logic [7:0] v);
    logic [8:0] q;
    logic [3:0] n;
    logic       use_xnor;
    n        = ones8(v);
    use_xnor = (n > 4'd4) || ((n == 4'd4) && (v[0] == 1'b0));
    q        = 9'd0;
    q[0]     = v[0];
    for (int k = 1; k < 8; k++) begin
      q[k] = use_xnor ? ~(q[k-1] ^ v[k]) : (q[k-1] ^ v[k]);
    end
    q[8] = ~use_xnor;
    return q;
  endfunction

  // Control-period symbol table.
  function automatic logic [9:0] ctrl_sym(input logic [1:0] c);
    logic [9:0] s;
    case (c)
      2'b00:   s = 10'h354;
      2'b01:   s = 10'h0AB;
      2'b10:   s = 10'h154;
      2'b11:   s = 10'h2AB;
      default: s = 10'h354;
    endcase
    return s;
  endfunction

  logic [8:0]        qm_s;
  logic [8:0]        q_m_d,  q_m_q;
  logic [3:0]        n1_d,   n1_q;
  logic              de_d,   de_q;
  logic [1:0]        ctrl_d, ctrl_q;
  logic [9:0]        sym_d,  sym_q;
  logic signed [4:0] cnt_d,  cnt_q;
  logic signed [4:0] n1_sv, n0_sv, diff_sv, bonus_sv, pen_sv;

  assign qm_s = tm_qm(d);

  // Stage 1 next-state: capture the minimised word and its ones count.
  always_comb begin
    q_m_d  = q_m_q;
    n1_d   = n1_q;
    de_d   = de_q;
    ctrl_d = ctrl_q;
    if (adv) begin
      q_m_d  = qm_s;
      n1_d   = ones8(qm_s[7:0]);
      de_d   = de;
      ctrl_d = ctrl;
    end else begin
      q_m_d  = q_m_q;
    end
  end

  // Stage 1 registers; reset to the blanked state.
  always_ff @(posedge clk_pixel or negedge resetn) begin
    if (!resetn) begin
      q_m_q  <= 9'd0;
      n1_q   <= 4'd0;
      de_q   <= 1'b0;
      ctrl_q <= 2'b00;
    end else begin
      q_m_q  <= q_m_d;
      n1_q   <= n1_d;
      de_q   <= de_d;
      ctrl_q <= ctrl_d;
    end
  end

  // Disparity helpers: diff = N1-N0; the +2/-2 terms come from q_m[8].
  assign n1_sv    = signed'({1'b0, n1_q});
  assign n0_sv    = 5'sd8 - n1_sv;
  assign diff_sv  = n1_sv - n0_sv;
  assign bonus_sv = q_m_q[8] ? 5'sd2 : 5'sd0;
  assign pen_sv   = q_m_q[8] ? 5'sd0 : 5'sd2;

  // Stage 2 next-state: DC-balanced symbol and running disparity.
  always_comb begin
    sym_d = sym_q;
    cnt_d = cnt_q;
    if (!adv) begin
      sym_d = sym_q;
    end else if (!de_q) begin
      // Control period: disparity restarts so each active run starts at 0.
      sym_d = ctrl_sym(ctrl_q);
      cnt_d = 5'sd0;
    end else if ((cnt_q == 5'sd0) || (n1_q == 4'd4)) begin
      sym_d = {~q_m_q[8], q_m_q[8], (q_m_q[8] ? q_m_q[7:0] : ~q_m_q[7:0])};
      cnt_d = q_m_q[8] ? (cnt_q + diff_sv) : (cnt_q - diff_sv);
    end else if (((cnt_q > 5'sd0) && (n1_q > 4'd4)) ||
                 ((cnt_q < 5'sd0) && (n1_q < 4'd4))) begin
      sym_d = {1'b1, q_m_q[8], ~q_m_q[7:0]};
      cnt_d = cnt_q + bonus_sv - diff_sv;
    end else begin
      sym_d = {1'b0, q_m_q[8], q_m_q[7:0]};
      cnt_d = cnt_q - pen_sv + diff_sv;
    end
  end

  // Stage 2 registers; reset emits control 00 with zero disparity.
  always_ff @(posedge clk_pixel or negedge resetn) begin
    if (!resetn) begin
      sym_q <= 10'h354;
      cnt_q <= 5'sd0;
    end else begin
      sym_q <= sym_d;
      cnt_q <= cnt_d;
    end
  end

  generate
    if (c_out_reg != 0) begin : g_out_reg
      logic [9:0] out_d, out_q;

      // Output stage next-state: follow stage 2 on advancing cycles.
      always_comb begin
        out_d = out_q;
        if (adv) begin
          out_d = sym_q;
        end else begin
          out_d = out_q;
        end
      end

      // Output register; reset also shows control 00.
      always_ff @(posedge clk_pixel or negedge resetn) begin
        if (!resetn) begin
          out_q <= 10'h354;
        end else begin
          out_q <= out_d;
        end
      end

      assign sym = out_q;
    end else begin : g_no_out_reg
      assign sym = sym_q;
    end
  endgenerate

endmodule

module vga2tmds_encoder #(
  parameter int         c_out_reg     = 1,
  parameter logic [9:0] c_clk_pattern = 10'b0000011111
) (
  input  logic       clk_pixel,
  input  logic       resetn,
  input  logic       clk_pixel_ena,
  input  logic [7:0] i_r,
  input  logic [7:0] i_g,
  input  logic [7:0] i_b,
  input  logic       i_hsync,
  input  logic       i_vsync,
  input  logic       i_blank,
  output logic [9:0] o_red,
  output logic [9:0] o_green,
  output logic [9:0] o_blue,
  output logic [9:0] o_clk
);

  logic adv_s;
  logic de_s;

`ifdef TMDS_CLK_ENA_EN
  assign adv_s = clk_pixel_ena;
`else
  logic unused_ena_s;
  assign unused_ena_s = clk_pixel_ena;
  assign adv_s        = 1'b1;
`endif

  assign de_s  = ~i_blank;
  assign o_clk = c_clk_pattern;

  vga2tmds_channel #(.c_out_reg(c_out_reg)) u_red (
    .clk_pixel (clk_pixel),
    .resetn    (resetn),
    .adv       (adv_s),
    .d         (i_r),
    .de        (de_s),
    .ctrl      (2'b00),
    .sym       (o_red)
  );

  vga2tmds_channel #(.c_out_reg(c_out_reg)) u_green (
    .clk_pixel (clk_pixel),
    .resetn    (resetn),
    .adv       (adv_s),
    .d         (i_g),
    .de        (de_s),
    .ctrl      (2'b00),
    .sym       (o_green)
  );

  // Blue carries sync during blank: c0 = hsync, c1 = vsync.
  vga2tmds_channel #(.c_out_reg(c_out_reg)) u_blue (
    .clk_pixel (clk_pixel),
    .resetn    (resetn),
    .adv       (adv_s),
    .d         (i_b),
    .de        (de_s),
    .ctrl      ({i_vsync, i_hsync}),
    .sym       (o_blue)
  );

endmodule

// File: tb/tb_vga2tmds_encoder.sv
// -----------------------------------------------------------------------------
// tb_vga2tmds_encoder
//   Self-checking bench for vga2tmds_encoder. A DVI encoder model built from
//   the encoding rules (integer disparity, bit loops) predicts every lane each
//   cycle; directed vectors with hand-computed symbols pin the model itself.
// -----------------------------------------------------------------------------
module tb_vga2tmds_encoder;

  localparam int OUT_REG = 1;
  localparam int LAT     = (OUT_REG != 0) ? 3 : 2;
  localparam int LOGN    = 8192;

`ifdef TMDS_CLK_ENA_EN
  localparam bit ENA_MODE = 1'b1;
`else
  localparam bit ENA_MODE = 1'b0;
`endif

  localparam logic [9:0] CTRL_SYM [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

  logic       clk = 1'b0;
  logic       resetn;
  logic       clk_pixel_ena;
  logic [7:0] i_r, i_g, i_b;
  logic       i_hsync, i_vsync, i_blank;
  logic [9:0] o_red, o_green, o_blue, o_clk;

  int tests  = 0;
  int errors = 0;

  vga2tmds_encoder #(.c_out_reg(OUT_REG), .c_clk_pattern(10'b0000011111)) dut (
    .clk_pixel     (clk),
    .resetn        (resetn),
    .clk_pixel_ena (clk_pixel_ena),
    .i_r           (i_r),
    .i_g           (i_g),
    .i_b           (i_b),
    .i_hsync       (i_hsync),
    .i_vsync       (i_vsync),
    .i_blank       (i_blank),
    .o_red         (o_red),
    .o_green       (o_green),
    .o_blue        (o_blue),
    .o_clk         (o_clk)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int ones(input logic [7:0] v);
    int n = 0;
    for (int k = 0; k < 8; k++) n += int'(v[k]);
    return n;
  endfunction

  function automatic logic [8:0] model_qm(input logic [7:0] v);
    logic [8:0] q;
    bit xn;
    int n = ones(v);
    xn = (n > 4) || (n == 4 && v[0] == 1'b0);
    q = 9'd0;
    q[0] = v[0];
    for (int k = 1; k < 8; k++) q[k] = xn ? !(q[k-1] ^ v[k]) : (q[k-1] ^ v[k]);
    q[8] = !xn;
    return q;
  endfunction

  function automatic logic [9:0] model_sym(input logic [7:0] v, input logic de,
                                           input logic [1:0] c, input int cnt);
    logic [8:0] q;
    int n1, n0;
    if (!de) return CTRL_SYM[c];
    q  = model_qm(v);
    n1 = ones(q[7:0]);
    n0 = 8 - n1;
    if (cnt == 0 || n1 == n0) return {!q[8], q[8], (q[8] ? q[7:0] : ~q[7:0])};
    if ((cnt > 0 && n1 > n0) || (cnt < 0 && n0 > n1)) return {1'b1, q[8], ~q[7:0]};
    return {1'b0, q[8], q[7:0]};
  endfunction

  function automatic int model_cnt(input logic [7:0] v, input logic de, input int cnt);
    logic [8:0] q;
    int n1, n0;
    if (!de) return 0;
    q  = model_qm(v);
    n1 = ones(q[7:0]);
    n0 = 8 - n1;
    if (cnt == 0 || n1 == n0) return q[8] ? cnt + (n1 - n0) : cnt + (n0 - n1);
    if ((cnt > 0 && n1 > n0) || (cnt < 0 && n0 > n1)) return cnt + 2 * int'(q[8]) + (n0 - n1);
    return cnt - 2 * int'(!q[8]) + (n1 - n0);
  endfunction

  // channel index: 0 = blue, 1 = green, 2 = red
  function automatic logic [7:0] ch_data(input int c);
    return (c == 0) ? i_b : ((c == 1) ? i_g : i_r);
  endfunction

  function automatic logic [1:0] ch_ctrl(input int c);
    return (c == 0) ? {i_vsync, i_hsync} : 2'b00;
  endfunction

  int         edge_cnt = 0;
  logic [9:0] m_pipe [3][LAT];
  int         m_cnt  [3];
  int         cnt_log [LOGN];
  logic [9:0] out_log [3][LOGN];

  // Edge counter used to index the logs.
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Model: encode the sample taken at each advancing edge and delay it LAT stages.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int c = 0; c < 3; c++) begin
        m_cnt[c] <= 0;
        for (int i = 0; i < LAT; i++) m_pipe[c][i] <= 10'h354;
      end
    end else if (!ENA_MODE || clk_pixel_ena) begin
      for (int c = 0; c < 3; c++) begin
        m_pipe[c][0] <= model_sym(ch_data(c), !i_blank, ch_ctrl(c), m_cnt[c]);
        m_cnt[c]     <= model_cnt(ch_data(c), !i_blank, m_cnt[c]);
        for (int i = 1; i < LAT; i++) m_pipe[c][i] <= m_pipe[c][i-1];
      end
      if (edge_cnt < LOGN) cnt_log[edge_cnt] <= model_cnt(i_b, !i_blank, m_cnt[0]);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare process: every falling edge, DUT against model; also log outputs.
  initial begin
    forever begin
      @(negedge clk);
      if (edge_cnt >= 1 && edge_cnt - 1 < LOGN) begin
        out_log[0][edge_cnt-1] = o_blue;
        out_log[1][edge_cnt-1] = o_green;
        out_log[2][edge_cnt-1] = o_red;
      end
      check("o_clk", o_clk, 10'b0000011111);
      if (!resetn) begin
        check("rst_blue", o_blue, 10'h354);
        check("rst_green", o_green, 10'h354);
        check("rst_red", o_red, 10'h354);
      end else begin
        check("model_blue", o_blue, m_pipe[0][LAT-1]);
        check("model_green", o_green, m_pipe[1][LAT-1]);
        check("model_red", o_red, m_pipe[2][LAT-1]);
        tests++;
        if (m_cnt[0] > 10 || m_cnt[0] < -10 || m_cnt[1] > 10 || m_cnt[1] < -10 ||
            m_cnt[2] > 10 || m_cnt[2] < -10) begin
          errors++;
          $display("FAIL cnt_bound: got %0d/%0d/%0d, expected |cnt|<=10",
                   m_cnt[0], m_cnt[1], m_cnt[2]);
        end
      end
    end
  end

  // Apply one pixel for one enabled edge; returns the index of the sampling edge.
  task automatic drive(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                       input logic hs, input logic vs, input logic bl, output int e);
    i_r = r; i_g = g; i_b = b;
    i_hsync = hs; i_vsync = vs; i_blank = bl;
    @(posedge clk);
    #1;
    e = edge_cnt - 1;
  endtask

  int e_tmp;
  int e_ctrl [4];
  int e3, e4;
  int blank_run;

  initial begin
    resetn = 1'b0;
    clk_pixel_ena = 1'b1;
    i_r = 8'h00; i_g = 8'h00; i_b = 8'h00;
    i_hsync = 1'b0; i_vsync = 1'b0; i_blank = 1'b1;

    // 1: reset held with random inputs
    repeat (4) begin
      @(posedge clk);
      #2;
      i_r = 8'($urandom); i_g = 8'($urandom); i_b = 8'($urandom);
      i_hsync = 1'($urandom); i_vsync = 1'($urandom); i_blank = 1'($urandom);
    end
    check("t1_red", o_red, 10'h354);
    check("t1_green", o_green, 10'h354);
    check("t1_blue", o_blue, 10'h354);
    check("t1_clk", o_clk, 10'b0000011111);
    resetn = 1'b1;

    // 2: control symbols on blue, red/green stay at 354
    for (int c = 0; c < 4; c++) begin
      drive(8'h5A, 8'hA5, 8'h3C, c[0], c[1], 1'b1, e_ctrl[c]);
      repeat (3) drive(8'h5A, 8'hA5, 8'h3C, c[0], c[1], 1'b1, e_tmp);
    end
    repeat (2) drive(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, e_tmp);

    // 3: three black pixels from blank
    drive(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, e3);
    repeat (2) drive(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, e_tmp);
    repeat (3) drive(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, e_tmp);

    // 4: white then 8'h10 from blank
    drive(8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, e4);
    drive(8'h10, 8'h10, 8'h10, 1'b0, 1'b0, 1'b0, e_tmp);
    repeat (LAT + 2) drive(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, e_tmp);

    for (int c = 0; c < 4; c++) begin
      check($sformatf("t2_blue_%0d", c), out_log[0][e_ctrl[c]+LAT-1], CTRL_SYM[c]);
      check($sformatf("t2_red_%0d", c), out_log[2][e_ctrl[c]+LAT-1], 10'h354);
      check($sformatf("t2_green_%0d", c), out_log[1][e_ctrl[c]+LAT-1], 10'h354);
    end
    check("t3_sym0", out_log[0][e3+LAT-1], 10'h100);
    check("t3_sym1", out_log[0][e3+LAT],   10'h3FF);
    check("t3_sym2", out_log[0][e3+LAT+1], 10'h100);
    check_int("t3_cnt0", cnt_log[e3],   -8);
    check_int("t3_cnt1", cnt_log[e3+1],  2);
    check_int("t3_cnt2", cnt_log[e3+2], -6);
    check("t4_qm_ff", {23'd0, model_qm(8'hFF)}, 9'h0FF);
    check("t4_red_ff", out_log[2][e4+LAT-1], 10'h200);
    check("t4_blue_ff", out_log[0][e4+LAT-1], 10'h200);
    check("t4_red_10", out_log[2][e4+LAT], 10'h1F0);
    check_int("t4_cnt_10", cnt_log[e4+1], -8);

    // 5/6: random pixels, random blanking, occasional async resets,
    // enable pattern 1,0,0,1 (ignored in the default build)
    blank_run = 0;
    for (int i = 0; i < 4096; i++) begin
      @(posedge clk);
      #2;
      if (blank_run == 0) begin
        i_blank   = ~i_blank;
        blank_run = int'($urandom_range(1, 40));
      end else begin
        blank_run--;
      end
      i_r = 8'($urandom); i_g = 8'($urandom); i_b = 8'($urandom);
      i_hsync = 1'($urandom); i_vsync = 1'($urandom);
      clk_pixel_ena = ((i % 4) == 0) || ((i % 4) == 3);
      if ($urandom_range(0, 255) == 0) begin
        #1 resetn = 1'b0;
        @(negedge clk);
        #1 resetn = 1'b1;
      end
    end
    clk_pixel_ena = 1'b1;
    repeat (LAT + 2) drive(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, e_tmp);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
